// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: parity selection and receive FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_DONE,
    RX_BRK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the serial line: two-flop synchroniser followed by a
// 3-deep majority filter, so single-clock glitches never reach the FSM.
module uart_rx_sampler (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_RX_Serial,
  output logic rx_bit
);

  logic [1:0] sync;
  logic [2:0] shift;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync  <= 2'b11;
      shift <= 3'b000;
    end else begin
      sync  <= {sync[0], i_RX_Serial};
      shift <= {shift[1:0], sync[1]};
    end
  end

  assign rx_bit = (shift[0] & shift[1]) | (shift[0] & shift[2]) | (shift[1] & shift[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with optional parity, 1/2 stop bits and break
// detection; one-clock o_RX_DV pulse with result and error flags per frame.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 217,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_chk_clks
    $fatal(1, "uart_rx_param: CLKS_PER_BIT out of range 8..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $fatal(1, "uart_rx_param: DATA_BITS out of range 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_chk_par
    $fatal(1, "uart_rx_param: illegal PARITY mode");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $fatal(1, "uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_bit;

  uart_rx_sampler u_sampler (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .i_RX_Serial(i_RX_Serial),
    .rx_bit     (rx_bit)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop_lo_q, stop_lo_d;
  logic                 stop_hi_q, stop_hi_d;
  logic                 dv_d, perr_d, ferr_d, brk_d;
  logic [DATA_BITS-1:0] byte_d;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_lo_q    <= 1'b0;
      stop_hi_q    <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      par_q        <= par_d;
      stop_idx_q   <= stop_idx_d;
      stop_lo_q    <= stop_lo_d;
      stop_hi_q    <= stop_hi_d;
      o_RX_DV      <= dv_d;
      o_RX_Byte    <= byte_d;
      o_Parity_Err <= perr_d;
      o_Frame_Err  <= ferr_d;
      o_Break      <= brk_d;
    end
  end

  // Result registers load on the edge into DONE, so they are visible in the DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_d      = par_q;
    stop_idx_d = stop_idx_q;
    stop_lo_d  = stop_lo_q;
    stop_hi_d  = stop_hi_q;
    dv_d       = 1'b0;
    byte_d     = o_RX_Byte;
    perr_d     = o_Parity_Err;
    ferr_d     = o_Frame_Err;
    brk_d      = o_Break;

    case (state_q)
      RX_IDLE: begin
        if (!rx_bit) begin
          cnt_d   = '0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rx_bit) begin
            idx_d      = '0;
            par_d      = 1'b0;
            stop_idx_d = 1'b0;
            stop_lo_d  = 1'b0;
            stop_hi_d  = 1'b0;
            state_d    = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_bit;
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          par_d   = rx_bit;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d     = '0;
          stop_lo_d = stop_lo_q | ~rx_bit;
          stop_hi_d = stop_hi_q | rx_bit;
          if (stop_idx_q == STOP_LAST) begin
            state_d = RX_DONE;
            dv_d    = 1'b1;
            brk_d   = (data_q == '0) && !par_q && !stop_hi_d;
            byte_d  = brk_d ? '0 : data_q;
            ferr_d  = stop_lo_d;
            case (PARITY)
              PAR_EVEN: perr_d = ^data_q ^ par_q;
              PAR_ODD:  perr_d = ~(^data_q ^ par_q);
              default:  perr_d = 1'b0;
            endcase
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DONE: begin
        state_d = o_Break ? RX_BRK_WAIT : RX_IDLE;
      end
      RX_BRK_WAIT: begin
        if (rx_bit) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 8E1, 7O2) fed by
// directed frames; monitors pop expected results whenever o_RX_DV fires.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [8:0] data;
    logic       par;
    logic       frm;
    logic       brk;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;

  logic       dv_a, perr_a, ferr_a, brk_a;
  logic [7:0] byte_a;
  logic       dv_b, perr_b, ferr_b, brk_b;
  logic [7:0] byte_b;
  logic       dv_c, perr_c, ferr_c, brk_c;
  logic [6:0] byte_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
    .i_Clock(clock), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[0]), .o_RX_DV(dv_a),
    .o_RX_Byte(byte_a), .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Break(brk_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
    .i_Clock(clock), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[1]), .o_RX_DV(dv_b),
    .o_RX_Byte(byte_b), .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Break(brk_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2)) dut_c (
    .i_Clock(clock), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[2]), .o_RX_DV(dv_c),
    .o_RX_Byte(byte_c), .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Break(brk_c));

  task automatic check_output(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check_frame(input string tag, input exp_t e, input logic [8:0] got_byte,
                             input logic got_par, input logic got_frm, input logic got_brk);
    check_output({tag, " byte"}, got_byte, e.data);
    check_output({tag, " parity_err"}, {8'd0, got_par}, {8'd0, e.par});
    check_output({tag, " frame_err"}, {8'd0, got_frm}, {8'd0, e.frm});
    check_output({tag, " break"}, {8'd0, got_brk}, {8'd0, e.brk});
  endtask

  task automatic unexpected_dv(input string tag);
    checks++;
    $display("[TB] FAIL %s unexpected o_RX_DV: got 1, expected 0", tag);
  endtask

  always @(negedge clock) begin
    if (dv_a) begin
      if (q_a.size() == 0) unexpected_dv("A");
      else check_frame("A", q_a.pop_front(), {1'b0, byte_a}, perr_a, ferr_a, brk_a);
    end
    if (dv_b) begin
      if (q_b.size() == 0) unexpected_dv("B");
      else check_frame("B", q_b.pop_front(), {1'b0, byte_b}, perr_b, ferr_b, brk_b);
    end
    if (dv_c) begin
      if (q_c.size() == 0) unexpected_dv("C");
      else check_frame("C", q_c.pop_front(), {2'b0, byte_c}, perr_c, ferr_c, brk_c);
    end
  end

  task automatic send_bit(input int k, input logic b, input bit glitch);
    for (int c = 0; c < CPB; c++) begin
      rx_line[k] = (glitch && c == CPB / 2) ? ~b : b;
      @(negedge clock);
    end
  endtask

  task automatic apply_stimulus(input int k, input int nbits, input logic [8:0] data,
                                input bit has_par, input logic par, input int nstop,
                                input logic [1:0] stops, input int glitch_bit);
    send_bit(k, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(k, data[i], glitch_bit == i);
    if (has_par) send_bit(k, par, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(k, stops[i], 1'b0);
  endtask

  task automatic idle_bits(input int n);
    rx_line = 3'b111;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " dv"}, {8'd0, dv_a}, 9'd0);
    check_output({tag, " byte"}, {1'b0, byte_a}, 9'd0);
    check_output({tag, " parity_err"}, {8'd0, perr_a}, 9'd0);
    check_output({tag, " frame_err"}, {8'd0, ferr_a}, 9'd0);
    check_output({tag, " break"}, {8'd0, brk_a}, 9'd0);
  endtask

  initial begin
    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_bits(3);

    // 8N1 basic frame
    q_a.push_back('{9'h037, 1'b0, 1'b0, 1'b0});
    apply_stimulus(0, 8, 9'h037, 1'b0, 1'b0, 1, 2'b11, -1);
    idle_bits(2);

    // Line held low 20 bit times: one break report, then normal frame
    q_a.push_back('{9'h000, 1'b0, 1'b1, 1'b1});
    rx_line[0] = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    idle_bits(2);
    q_a.push_back('{9'h05A, 1'b0, 1'b0, 1'b0});
    apply_stimulus(0, 8, 9'h05A, 1'b0, 1'b0, 1, 2'b11, -1);
    idle_bits(2);

    // Single-clock glitches are filtered
    rx_line[0] = 1'b0;
    @(negedge clock);
    idle_bits(3);
    q_a.push_back('{9'h000, 1'b0, 1'b0, 1'b0});
    apply_stimulus(0, 8, 9'h000, 1'b0, 1'b0, 1, 2'b11, 3);
    idle_bits(2);

    // Back-to-back frames without an idle gap
    q_a.push_back('{9'h001, 1'b0, 1'b0, 1'b0});
    q_a.push_back('{9'h0FF, 1'b0, 1'b0, 1'b0});
    apply_stimulus(0, 8, 9'h001, 1'b0, 1'b0, 1, 2'b11, -1);
    apply_stimulus(0, 8, 9'h0FF, 1'b0, 1'b0, 1, 2'b11, -1);
    idle_bits(2);

    // 8E1: 0xA5 has even ones, so parity bit 1 is wrong and 0 is right
    q_b.push_back('{9'h0A5, 1'b1, 1'b0, 1'b0});
    apply_stimulus(1, 8, 9'h0A5, 1'b1, 1'b1, 1, 2'b11, -1);
    idle_bits(2);
    q_b.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    apply_stimulus(1, 8, 9'h0A5, 1'b1, 1'b0, 1, 2'b11, -1);
    idle_bits(2);

    // 7O2: 0x41 has two ones, odd parity bit is 1; second stop low
    q_c.push_back('{9'h041, 1'b0, 1'b1, 1'b0});
    apply_stimulus(2, 7, 9'h041, 1'b1, 1'b1, 2, 2'b01, -1);
    idle_bits(3);

    // Reset mid-frame abandons the frame and clears the held outputs
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("midframe reset");
    rx_line[0] = 1'b1;
    repeat (CPB) @(negedge clock);
    rst_n = 1'b1;
    idle_bits(4);

    check_output("A pending frames", 9'(q_a.size()), 9'd0);
    check_output("B pending frames", 9'(q_b.size()), 9'd0);
    check_output("C pending frames", 9'(q_c.size()), 9'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, SHALL set clocks per UART bit (i_Clock freq / baud); legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default PAR_NONE, SHALL select parity mode: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the number of stop bits checked; legal values 1, 2.
REQ-005 i_Clock  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 i_Rst_L  input  1  SHALL be the reset, asynchronous and active-low.
REQ-007 i_RX_Serial  input  1  SHALL be the asynchronous serial line; idle high.
REQ-008 o_RX_DV  output  1  SHALL pulse high for exactly one clock per completed frame.
REQ-009 o_RX_Byte  output  DATA_BITS  SHALL hold the last received data word, LSB-first on the line.
REQ-010 o_Parity_Err  output  1  SHALL flag a parity mismatch for the frame reported by o_RX_DV.
REQ-011 o_Frame_Err  output  1  SHALL flag any stop bit sampled low for the frame reported by o_RX_DV.
REQ-012 o_Break  output  1  SHALL flag a break condition for the frame reported by o_RX_DV.

Function
REQ-013 i_RX_Serial SHALL pass through a 2-flop synchroniser, then a 3-deep shift register; the bit value SHALL be the majority of the 3 entries.
REQ-014 Bit counter width SHALL be $clog2(CLKS_PER_BIT); sample point HALF = (CLKS_PER_BIT-1)/2.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT.
REQ-016 IDLE: on majority value 0, clear counter, go to START.
REQ-017 START: at count HALF, majority 0 -> clear counter, go DATA; majority 1 -> false start, go IDLE with no output change.
REQ-018 DATA: every CLKS_PER_BIT clocks, store majority into bit index (0 first); after bit DATA_BITS-1 go to PARITY if PARITY != PAR_NONE, else STOP.
REQ-019 PARITY: after CLKS_PER_BIT clocks, sample the bit; error if XOR(data, bit) is 1 for EVEN or 0 for ODD.
REQ-020 STOP: sample each stop bit CLKS_PER_BIT clocks after the previous sample; any low sample sets the frame error; after the last stop sample go to DONE.
REQ-021 DONE (one clock): assert o_RX_DV; update o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break together; go to BRK_WAIT if break, else IDLE.
REQ-022 Break SHALL mean all data, parity (if any) and stop samples are 0; o_Break=1, o_Frame_Err=1, o_RX_Byte=0.
REQ-023 BRK_WAIT SHALL stay until majority value is 1, then go to IDLE; no start detection while in BRK_WAIT.
REQ-024 o_RX_DV SHALL assert at the mid-point of the last stop bit plus 1 clock, so a start bit immediately following is not missed.
REQ-025 o_RX_Byte and error flags SHALL hold their values until the next DONE; flags SHALL never change outside DONE.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 While i_Rst_L=0: state IDLE; counters, shift registers and bit index 0; synchroniser flops 1; o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no o_RX_DV; reception restarts at the next falling edge after release.

Structure
REQ-029 Package uart_pkg SHALL hold the parity-mode enum (PAR_NONE/PAR_EVEN/PAR_ODD) and the RX state enum.
REQ-030 Sub-module uart_rx_sampler SHALL contain the synchroniser and majority filter, exporting one filtered bit.
REQ-031 Parameter legality (REQ-001..004) SHALL be checked at elaboration with fatal error on violation.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-032 8N1, send 0x37 -> single o_RX_DV with o_RX_Byte=0x37 and all flags 0.
REQ-033 8E1, send 0xA5 with parity bit 1 -> o_RX_DV, o_RX_Byte=0xA5, o_Parity_Err=1; resend with parity 0 -> o_Parity_Err=0.
REQ-034 7O2, send 0x41 with second stop bit 0 -> o_Frame_Err=1, o_Parity_Err=0, o_RX_Byte=0x41.
REQ-035 Line held low for 20 bit times -> exactly one o_RX_DV with o_Break=1, o_RX_Byte=0; next frame 0x5A after line high is received correctly.
REQ-036 1-clock low glitch in idle -> no o_RX_DV; 1-clock inverted glitch at mid-bit 3 of 0x00 -> o_RX_Byte=0x00.
REQ-037 Back-to-back frames 0x01, 0xFF with no idle gap -> two o_RX_DV pulses in order; reset pulse mid-frame -> no o_RX_DV and all outputs 0.
